// File: rtl/rom_fetch_pkg.sv
// Shared types and constants for the ROM instruction prefetch stage.
package rom_fetch_pkg;
  localparam int ADDR_W = 24;
  localparam int WORD_W = 32;
  localparam logic [ADDR_W-1:0] BASE_DEFAULT = 24'h05_0000;

  typedef enum logic [1:0] {ST_SETTLE, ST_WAIT, ST_HOLD} fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with fall-through head, flush and occupancy count.
module sync_fifo #(
  parameter int WIDTH = 56,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data  = mem[rd_ptr];
  assign head_valid = (count != '0);
endmodule

// File: rtl/rom_prefetch.sv
// Sequential prefetcher in front of Parallel_ROM: walks word addresses,
// buffers returned words and serves them on a valid/ready port.
module rom_prefetch
  import rom_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE   = BASE_DEFAULT,
  parameter int                DEPTH  = 4,
  parameter int                SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  input  logic              rom_readyn,
  output logic              fetch_valid,
  input  logic              fetch_ready,
  output logic [WORD_W-1:0] fetch_data,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              busy
);
  localparam int CW = $clog2(SETTLE + 1);
  localparam int NW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE);
  localparam logic [NW:0]   FULL      = (NW+1)'(DEPTH);

  fetch_state_t      state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NW-1:0]     count;
  logic [NW:0]       cnt_after;
  logic              push, pop;
  fetch_entry_t      entry_in, head;

  // A redirect squashes both a completing word and a same-cycle pop.
  assign push = (state_q == ST_WAIT) && !rom_readyn && !redirect;
  assign pop  = fetch_valid && fetch_ready && !redirect;
  assign cnt_after = {1'b0, count} + (NW+1)'(push) - (NW+1)'(pop);

  assign entry_in.addr = addr_q;
  assign entry_in.data = rom_data;

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect),
    .push       (push),
    .push_data  (entry_in),
    .pop        (pop),
    .head_data  (head),
    .head_valid (fetch_valid),
    .count      (count)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    if (redirect) begin
      addr_d  = {redirect_addr[ADDR_W-1:2], 2'b00};
      state_d = ST_SETTLE;
      cnt_d   = SETTLE_LD;
    end else begin
      case (state_q)
        ST_SETTLE: begin
          if (cnt_q == '0) state_d = ST_WAIT;
          else             cnt_d   = cnt_q - CW'(1);
        end
        ST_WAIT: begin
          if (push) begin
            addr_d = addr_q + ADDR_W'(4);
            // Park with the next address already presented when the buffer fills.
            if (cnt_after < FULL) begin
              state_d = ST_SETTLE;
              cnt_d   = SETTLE_LD;
            end else begin
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if ({1'b0, count} < FULL) begin
            state_d = ST_SETTLE;
            cnt_d   = SETTLE_LD;
          end
        end
        default: begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LD;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_SETTLE;
      cnt_q   <= SETTLE_LD;
      addr_q  <= BASE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  assign rom_addr   = addr_q;
  assign busy       = (state_q != ST_HOLD);
  assign fetch_data = head.data;
  assign fetch_addr = head.addr;
endmodule
